fpu_sideband_pipe: RTL
======================

# fpu_sideband_pipe

Parametrised sideband pipeline for the SIMD FP store/convert cluster. Carries each issue port's opcode, valid and extract-subtract flag through a configurable number of stages alongside the datapath, producing the per-port "subtract-chain select" vector at the final stage. It also merges per-lane retire buses into one retire per port and tracks in-flight ops per port. It sits between the issue ports and the lane datapath instances, replacing fixed 3-port/3-stage hand-written op registers.

## Interface
- NCH, 3: number of issue ports (channels)
- NLANE, 2: number of datapath lanes whose retire buses are merged
- DEPTH, 3: pipeline stages (>=1)
- OPW, 21: opcode width
- RETW, 14: retire tag width
- SUB_BIT, 10: opcode bit index that marks a subtract-chain op (< OPW)
- CNTW, 4: in-flight counter width

- clk  in  1  clock; all state updates on rising edge (falling edge when `swapedge` is defined)
- rst  in  1  reset; synchronous and active-high
- in_en  in  NCH  per-channel issue valid
- in_op  in  NCH*OPW  per-channel opcode; channel c at [c*OPW +: OPW]
- in_xsub  in  NCH  per-channel extract-subtract flag
- flush  in  1  kills all in-flight state
- lane_ret  in  NLANE*NCH*RETW  lane l, channel c at [(l*NCH+c)*RETW +: RETW]
- lane_ret_en  in  NLANE*NCH  lane l, channel c at bit l*NCH+c
- pipe_op  out  NCH*OPW  opcode at final stage
- pipe_vld  out  NCH  valid at final stage
- sub_sel  out  NCH  pipe_vld & pipe_op[SUB_BIT] & ~xsub at final stage
- ret  out  NCH*RETW  OR of all lanes' ret for the channel (combinational)
- ret_en  out  NCH  OR of all lanes' ret_en for the channel (combinational)
- inflight  out  NCH*CNTW  per-channel in-flight count
- busy  out  NCH  inflight != 0
- err_ovf  out  NCH  sticky: accept while count at max
- err_unf  out  NCH  sticky: retire while count is 0
- err_conf  out  NCH  sticky: two lanes retire same channel same cycle with differing tags

## Operation
- Per channel, per stage k (1..DEPTH): registers op_k, xsub_k, vld_k. Stage 1 loads in_op/in_xsub/in_en; stage k loads stage k-1. Payload (op, xsub) advances every cycle regardless of valid; only vld gates outputs.
- Every stage's xsub advances from the previous stage; no stage holds its own value.
- pipe_op/pipe_vld/sub_sel come from stage DEPTH registers only; sub_sel is the registered stage-DEPTH fields combined combinationally.
- flush: all vld_k cleared next edge, in_en on the flush cycle is dropped; payload still advances; inflight counters reset to 0; sticky errors unaffected.
- Retire merge: ret/ret_en are bitwise OR across lanes, no registering. A channel's ret_en counts as one retire even if several lanes assert it.
- Counter per channel, when not flush: inc = in_en[c], dec = ret_en[c].
  - inc & ~dec: +1; at all-ones, count holds and err_ovf[c] sets.
  - dec & ~inc: -1; at 0, count holds 0 and err_unf[c] sets.
  - inc & dec: unchanged (no error even at 0 or max).
- err_conf[c] sets when >=2 lanes assert ret_en for c in one cycle and their ret tags are not all equal.
- Sticky errors clear only on rst.

## Timing
- Reset: every stage op/xsub/vld = 0, inflight = 0, all err_* = 0. Thus pipe_op = 0, pipe_vld = 0, sub_sel = 0, busy = 0 the cycle after rst edge. ret/ret_en follow lane inputs even during rst.
- Latency: in_* sampled at edge t appear on pipe_* after edge t+DEPTH-1 (DEPTH cycles of registering), i.e. DEPTH=3 → visible 3 cycles after issue.
- Throughput: one op per channel per cycle; no backpressure.
- rst and flush together: rst wins (identical result apart from errors clearing).
- rst mid-pipeline: all in-flight ops lost; no sub_sel pulse emitted for them.
- Counter and error updates occur on the same edge as the causing event; flags visible next cycle.

## Test plan
- Latency: DEPTH=3, issue ch1 op=0x00400 (bit10 set), xsub=0 at cycle 0 -> pipe_vld[1]=1, sub_sel[1]=1 exactly at cycle 3, 0 at cycles 2 and 4.
- xsub gating: same op with xsub=1 on ch2 -> pipe_vld[2]=1, sub_sel[2]=0 at cycle 3; back-to-back xsub=0,1,0 yields sub_sel 1,0,1.
- Flush: issue ch0 cycles 0,1; flush at cycle 2 -> pipe_vld[0] never rises; inflight[0]=0, busy[0]=0 from cycle 3.
- Counter: 3 issues on ch0 then ret_en from lane1 ch0 and issue simultaneously -> inflight 3 stays 3; then 3 retires -> 0, busy=0; fourth retire -> err_unf[0]=1, count 0.
- Overflow, CNTW=4: 16 issues without retire -> count 15, err_ovf=1 on 16th.
- Conflict: lane0 ret=0x12, lane1 ret=0x13 both enabled ch2 -> ret=0x13, ret_en=1, err_conf[2]=1; equal tags 0x12/0x12 -> no error, counter decrements once.

Source files
------------

// File: rtl/fpu_sideband_pipe.sv
// Sideband pipeline for the SIMD FP store/convert cluster: carries per-port opcode/valid/xsub
// through DEPTH stages, merges lane retire buses and tracks in-flight ops per port.
module fpu_sideband_pipe #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned NLANE   = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned OPW     = 21,
  parameter int unsigned RETW    = 14,
  parameter int unsigned SUB_BIT = 10,
  parameter int unsigned CNTW    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            in_en,
  input  logic [NCH*OPW-1:0]        in_op,
  input  logic [NCH-1:0]            in_xsub,
  input  logic                      flush,
  input  logic [NLANE*NCH*RETW-1:0] lane_ret,
  input  logic [NLANE*NCH-1:0]      lane_ret_en,
  output logic [NCH*OPW-1:0]        pipe_op,
  output logic [NCH-1:0]            pipe_vld,
  output logic [NCH-1:0]            sub_sel,
  output logic [NCH*RETW-1:0]       ret,
  output logic [NCH-1:0]            ret_en,
  output logic [NCH*CNTW-1:0]       inflight,
  output logic [NCH-1:0]            busy,
  output logic [NCH-1:0]            err_ovf,
  output logic [NCH-1:0]            err_unf,
  output logic [NCH-1:0]            err_conf
);

  logic clk_e;
`ifdef swapedge
  assign clk_e = ~clk;
`else
  assign clk_e = clk;
`endif

  logic [NCH*OPW-1:0] op_q   [DEPTH];
  logic [NCH-1:0]     xsub_q [DEPTH];
  logic [NCH-1:0]     vld_q  [DEPTH];

  // Payload always shifts; only the valid bits are killed by flush.
  always_ff @(posedge clk_e) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        op_q[k]   <= '0;
        xsub_q[k] <= '0;
        vld_q[k]  <= '0;
      end
    end else begin
      op_q[0]   <= in_op;
      xsub_q[0] <= in_xsub;
      vld_q[0]  <= flush ? '0 : in_en;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        op_q[k]   <= op_q[k-1];
        xsub_q[k] <= xsub_q[k-1];
        vld_q[k]  <= flush ? '0 : vld_q[k-1];
      end
    end
  end

  assign pipe_op  = op_q[DEPTH-1];
  assign pipe_vld = vld_q[DEPTH-1];

  always_comb begin
    sub_sel = '0;
    for (int unsigned c = 0; c < NCH; c++)
      sub_sel[c] = vld_q[DEPTH-1][c] & op_q[DEPTH-1][c*OPW+SUB_BIT] & ~xsub_q[DEPTH-1][c];
  end

  // Lane buses are lane-major, so each lane slice lines up with the merged bus.
  always_comb begin
    ret    = '0;
    ret_en = '0;
    for (int unsigned l = 0; l < NLANE; l++) begin
      ret    = ret    | lane_ret[l*NCH*RETW +: NCH*RETW];
      ret_en = ret_en | lane_ret_en[l*NCH +: NCH];
    end
  end

  logic [NCH-1:0]  conf;
  logic [NCH-1:0]  seen;
  logic [RETW-1:0] first_tag [NCH];

  always_comb begin
    conf = '0;
    seen = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      first_tag[c] = '0;
      for (int unsigned l = 0; l < NLANE; l++) begin
        if (lane_ret_en[l*NCH+c]) begin
          if (!seen[c]) begin
            first_tag[c] = lane_ret[(l*NCH+c)*RETW +: RETW];
            seen[c]      = 1'b1;
          end else if (lane_ret[(l*NCH+c)*RETW +: RETW] != first_tag[c]) begin
            conf[c] = 1'b1;
          end
        end
      end
    end
  end

  logic [CNTW-1:0] cnt_q [NCH];

  always_ff @(posedge clk_e) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) cnt_q[c] <= '0;
      err_ovf  <= '0;
      err_unf  <= '0;
      err_conf <= '0;
    end else begin
      err_conf <= err_conf | conf;
      for (int unsigned c = 0; c < NCH; c++) begin
        if (flush) begin
          cnt_q[c] <= '0;
        end else begin
          case ({in_en[c], ret_en[c]})
            2'b10: begin
              if (cnt_q[c] == '1) err_ovf[c] <= 1'b1;
              else                cnt_q[c]   <= cnt_q[c] + 1'b1;
            end
            2'b01: begin
              if (cnt_q[c] == '0) err_unf[c] <= 1'b1;
              else                cnt_q[c]   <= cnt_q[c] - 1'b1;
            end
            default: cnt_q[c] <= cnt_q[c];
          endcase
        end
      end
    end
  end

  always_comb begin
    inflight = '0;
    busy     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      inflight[c*CNTW +: CNTW] = cnt_q[c];
      busy[c]                  = |cnt_q[c];
    end
  end

endmodule
